can_error_frame_tx: RTL and testbench
=====================================

Name: can_error_frame_tx

Overview:
- Transmit-side counterpart to the CAN error monitors: when a monitor flags an error, this block drives a CAN error frame onto the TX line.
- The error frame is an error flag, then error-flag superposition waiting, then the error delimiter, with optional intermission.
- Bit-timed by a clock-divider counter.
- Publishes its current field on a 5-bit frame-field code so the monitors can track it.

Parameters:
- CLKS_PER_BIT, 10, clocks per CAN bit; must be >= 4.
- FLAG_BITS, 6, error-flag length in bits.
- DELIM_BITS, 8, error-delimiter length in bits; the first recessive bit sampled during WAIT counts as bit 1.
- WAIT_MAX_BITS, 14, dominant bits tolerated in WAIT before o_Stuck pulses.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_Error  in  1  error request (OR of monitor outputs); level or pulse.
- i_Error_Passive  in  1  1 = node is error-passive, so it sends a recessive flag.
- i_Rx_Data  in  1  sampled bus level; 1 = recessive.
- o_Tx_Data  out  1  TX line; 1 = recessive.
- o_Tx_Active  out  1  high from the first flag bit through the last transmitted bit.
- o_frame_field  out  5  11000 = error flag, 11011 = WAIT, 11001 = delimiter, 11010 = intermission, 00000 = idle.
- o_Done  out  1  one-cycle pulse at frame completion.
- o_Stuck  out  1  one-cycle pulse when the WAIT timeout is reached.

Behaviour:
- Reset (asynchronous, any state): state = IDLE, o_Tx_Data = 1, o_Tx_Active = 0, o_frame_field = 00000, o_Done = 0, o_Stuck = 0, all counters = 0.
  - Reset mid-frame aborts immediately; o_Tx_Data returns to 1 asynchronously.
- All outputs are registered.
- Bit timing:
  - clk_cnt counts 0..CLKS_PER_BIT-1.
  - The bit boundary is at clk_cnt = CLKS_PER_BIT-1.
  - bit_cnt increments at each boundary.
  - clk_cnt and bit_cnt clear on every state entry.
- IDLE:
  - i_Error = 1 sampled at edge N → at edge N the block enters FLAG with clk_cnt = 0.
  - o_Tx_Data is dominant from cycle N+1 (one-cycle latency).
  - i_Error_Passive is latched at the same edge and held for the whole frame.
- FLAG:
  - o_Tx_Data = 0 (active) or 1 (passive); o_frame_field = 11000.
  - Lasts FLAG_BITS bits, then the block enters WAIT.
- WAIT:
  - o_Tx_Data = 1; o_frame_field = 11011.
  - i_Rx_Data is sampled at clk_cnt = CLKS_PER_BIT/2.
  - Sample = 1: the current bit is delimiter bit 1. At that bit's boundary the block enters DELIM with bit_cnt preset to 1.
  - Sample = 0: at the boundary the wait bit counter increments.
  - On reaching WAIT_MAX_BITS: o_Stuck pulses, the wait counter clears, and the block stays in WAIT.
- DELIM:
  - o_Tx_Data = 1; o_frame_field = 11001.
  - Ends when bit_cnt reaches DELIM_BITS at a boundary. No bus checking occurs in DELIM.
- Completion:
  - The cycle after the final bit's last clock: o_Done = 1 for one cycle, o_Tx_Active = 0, o_frame_field = 00000, state = IDLE.
- i_Error while not in IDLE: ignored, with no queuing.
- i_Error held high across o_Done: a new frame starts at the edge where the state is IDLE, so there is one IDLE cycle minimum between frames.
- o_Tx_Active = 1 in FLAG, WAIT and DELIM (and in INTER when enabled).

Optional Feature:
- Macro CAN_INTERMISSION_EN.
- Defined: after DELIM the block enters INTER for 3 recessive bits, with o_frame_field = 11010 and o_Tx_Active = 1.
  - o_Done pulses after INTER ends.
  - i_Error during INTER is ignored.
- Undefined: there is no INTER state, and o_Done follows DELIM directly.

Test Plan:
1. Active error, CLKS_PER_BIT = 10, i_Rx_Data = 1 throughout, i_Error pulse at edge 0:
   - o_Tx_Data = 0 for cycles 1..60, then 1.
   - DELIM is entered at cycle 71.
   - o_Done pulses at cycle 141 (feature off), o_Tx_Active low from cycle 141.
2. Passive error, i_Error_Passive = 1, same stimulus: o_Tx_Data stays 1 throughout; o_frame_field sequence and o_Done timing are identical to scenario 1.
3. Superposition: i_Rx_Data = 0 for 3 extra bits after the flag ends (cycles 61..90), then 1 → DELIM entered at cycle 101, o_Done at cycle 171.
4. Stuck bus: i_Rx_Data held 0 after the flag → o_Stuck pulses every 140 cycles, o_Done never asserts, o_Tx_Data = 1.
5. Reset: i_Reset_n low at cycle 30 mid-flag → o_Tx_Data = 1 and o_Tx_Active = 0 immediately. After release, i_Error = 1 restarts a full 60-cycle flag.
6. CAN_INTERMISSION_EN defined, scenario 1 stimulus:
   - o_frame_field = 11010 for cycles 141..170, o_Done at cycle 171.
   - i_Error pulsed at cycle 150 is ignored.

Source files
------------

// File: rtl/can_error_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : can_error_frame_tx
// Purpose  : Drives a CAN error frame on the TX line when a monitor flags an
//            error: error flag, flag-superposition wait, error delimiter and
//            (optionally) a 3-bit intermission. Bit-timed by a clock divider.
// Ports    : i_Clock          system clock
//            i_Reset_n        asynchronous active-low reset
//            i_Error          error request (level or pulse)
//            i_Error_Passive  1 = send recessive (passive) flag
//            i_Rx_Data        sampled bus level, 1 = recessive
//            o_Tx_Data        TX line, 1 = recessive
//            o_Tx_Active      high while an error frame is being sent
//            o_frame_field    11000 flag / 11011 wait / 11001 delim /
//                             11010 intermission / 00000 idle
//            o_Done           one-cycle pulse at frame completion
//            o_Stuck          one-cycle pulse on WAIT timeout
// Options  : CAN_INTERMISSION_EN - adds the 3-bit INTER state after DELIM
// Revision : 1.0 - initial release
// ============================================================================
module can_error_frame_tx #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int FLAG_BITS     = 6,
    parameter int DELIM_BITS    = 8,
    parameter int WAIT_MAX_BITS = 14
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Error,
    input  logic       i_Error_Passive,
    input  logic       i_Rx_Data,
    output logic       o_Tx_Data,
    output logic       o_Tx_Active,
    output logic [4:0] o_frame_field,
    output logic       o_Done,
    output logic       o_Stuck
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CLK_HALF  = CW'(CLKS_PER_BIT / 2);
    localparam logic [7:0]    c_FLAG_LAST  = 8'(FLAG_BITS - 1);
    localparam logic [7:0]    c_DELIM_LAST = 8'(DELIM_BITS - 1);
    localparam logic [7:0]    c_INTER_LAST = 8'd2;
    localparam logic [7:0]    c_WAIT_LAST  = 8'(WAIT_MAX_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLAG  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DELIM = 3'd3;
    localparam logic [2:0] S_INTER = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_clk_cnt;
    logic [7:0]    r_bit_cnt;
    logic [7:0]    r_wait_cnt;
    logic          r_rx_rec;
    logic          r_passive;
    logic          r_done_evt;
    logic          r_stuck_evt;
    logic          w_bound;

    logic          r_tx, r_active, r_done, r_stuck;
    logic [4:0]    r_field;
    logic          w_tx, w_active, w_done, w_stuck;
    logic [4:0]    w_field;

    assign w_bound = (r_clk_cnt == c_CLK_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_Error) w_next = S_FLAG;
            S_FLAG:  if (w_bound && r_bit_cnt == c_FLAG_LAST) w_next = S_WAIT;
            // r_rx_rec holds the mid-bit sample of the current bit; a recessive
            // sample makes this bit the first delimiter bit.
            S_WAIT:  if (w_bound && r_rx_rec) w_next = S_DELIM;
            S_DELIM: begin
                if (w_bound && r_bit_cnt == c_DELIM_LAST) begin
`ifdef CAN_INTERMISSION_EN
                    w_next = S_INTER;
`else
                    w_next = S_IDLE;
`endif
                end
            end
            S_INTER: if (w_bound && r_bit_cnt == c_INTER_LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- bit timing, counters and events ----------------
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_rx_rec    <= 1'b0;
            r_passive   <= 1'b0;
            r_done_evt  <= 1'b0;
            r_stuck_evt <= 1'b0;
        end else begin
            r_done_evt  <= (r_state != S_IDLE) && (w_next == S_IDLE);
            r_stuck_evt <= 1'b0;
            if (r_state == S_IDLE && w_next == S_FLAG) begin
                r_passive <= i_Error_Passive;
            end
            if (w_next != r_state) begin
                r_clk_cnt  <= '0;
                // The WAIT bit that saw recessive already counts as delimiter bit 1
                r_bit_cnt  <= (w_next == S_DELIM) ? 8'd1 : 8'd0;
                r_wait_cnt <= '0;
                r_rx_rec   <= 1'b0;
            end else if (r_state != S_IDLE) begin
                if (w_bound) begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                end else begin
                    r_clk_cnt <= r_clk_cnt + 1'b1;
                end
                if (r_state == S_WAIT) begin
                    if (r_clk_cnt == c_CLK_HALF) begin
                        r_rx_rec <= i_Rx_Data;
                    end
                    // Staying in WAIT at a boundary means the bit was dominant
                    if (w_bound) begin
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            r_wait_cnt  <= '0;
                            r_stuck_evt <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- output decode ----------------
    always_comb begin
        w_tx     = 1'b1;
        w_active = 1'b0;
        w_field  = 5'b00000;
        w_done   = r_done_evt;
        w_stuck  = r_stuck_evt;
        case (r_state)
            S_FLAG: begin
                w_tx     = r_passive;
                w_active = 1'b1;
                w_field  = 5'b11000;
            end
            S_WAIT: begin
                w_active = 1'b1;
                w_field  = 5'b11011;
            end
            S_DELIM: begin
                w_active = 1'b1;
                w_field  = 5'b11001;
            end
            S_INTER: begin
                w_active = 1'b1;
                w_field  = 5'b11010;
            end
            default: ;
        endcase
    end

    // Registered outputs (one cycle behind the state)
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_field  <= 5'b00000;
            r_done   <= 1'b0;
            r_stuck  <= 1'b0;
        end else begin
            r_tx     <= w_tx;
            r_active <= w_active;
            r_field  <= w_field;
            r_done   <= w_done;
            r_stuck  <= w_stuck;
        end
    end

    assign o_Tx_Data     = r_tx;
    assign o_Tx_Active   = r_active;
    assign o_frame_field = r_field;
    assign o_Done        = r_done;
    assign o_Stuck       = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_can_error_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_error_frame_tx
// Purpose  : Directed self-checking bench for can_error_frame_tx
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_error_frame_tx;

    logic       clk;
    logic       rst_n;
    logic       i_Error, i_Error_Passive, i_Rx_Data;
    logic       o_Tx_Data, o_Tx_Active, o_Done, o_Stuck;
    logic [4:0] o_frame_field;

    int total = 0;
    int bad   = 0;

    localparam int NREC = 600;
    logic       rec_tx  [NREC];
    logic       rec_act [NREC];
    logic       rec_done[NREC];
    logic       rec_stk [NREC];
    logic [4:0] rec_fld [NREC];

    int first_dom, last_dom, n_dom, first_done, n_done, first_stk, second_stk, n_stk;

    can_error_frame_tx #(
        .CLKS_PER_BIT (10),
        .FLAG_BITS    (6),
        .DELIM_BITS   (8),
        .WAIT_MAX_BITS(14)
    ) dut (
        .i_Clock        (clk),
        .i_Reset_n      (rst_n),
        .i_Error        (i_Error),
        .i_Error_Passive(i_Error_Passive),
        .i_Rx_Data      (i_Rx_Data),
        .o_Tx_Data      (o_Tx_Data),
        .o_Tx_Active    (o_Tx_Active),
        .o_frame_field  (o_frame_field),
        .o_Done         (o_Done),
        .o_Stuck        (o_Stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edge 0 is the edge that samples i_Error. After edge e (+1 time unit)
    // outputs are recorded as cycle e, then inputs for cycle e are applied.
    task automatic run_frame(input logic passive, input int rx0_s, input int rx0_e,
                             input int err_at, input int ncyc);
        @(negedge clk);
        i_Error         = 1'b1;
        i_Error_Passive = passive;
        i_Rx_Data       = 1'b1;
        for (int e = 0; e <= ncyc; e++) begin
            @(posedge clk);
            #1;
            rec_tx[e]   = o_Tx_Data;
            rec_act[e]  = o_Tx_Active;
            rec_done[e] = o_Done;
            rec_stk[e]  = o_Stuck;
            rec_fld[e]  = o_frame_field;
            i_Error         = (e == err_at);
            i_Error_Passive = 1'b0;
            i_Rx_Data       = (e >= rx0_s && e < rx0_e) ? 1'b0 : 1'b1;
        end
        i_Error   = 1'b0;
        i_Rx_Data = 1'b1;
    endtask

    task automatic analyze(input int ncyc);
        first_dom = -1; last_dom = -1; n_dom = 0;
        first_done = -1; n_done = 0;
        first_stk = -1; second_stk = -1; n_stk = 0;
        for (int e = 0; e <= ncyc; e++) begin
            if (rec_tx[e] == 1'b0) begin
                if (first_dom < 0) first_dom = e;
                last_dom = e;
                n_dom++;
            end
            if (rec_done[e]) begin
                if (first_done < 0) first_done = e;
                n_done++;
            end
            if (rec_stk[e]) begin
                if (n_stk == 0) first_stk = e;
                if (n_stk == 1) second_stk = e;
                n_stk++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; i_Error = 1'b0; i_Error_Passive = 1'b0; i_Rx_Data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx",     int'(o_Tx_Data), 1);
        chk("rst_active", int'(o_Tx_Active), 0);
        chk("rst_field",  int'(o_frame_field), 0);
        chk("rst_done",   int'(o_Done) + int'(o_Stuck), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: active error flag, bus recessive
        run_frame(1'b0, -1, -1, -1, 260);
        analyze(260);
        chk("s1_first_dom", first_dom, 1);
        chk("s1_last_dom",  last_dom, 60);
        chk("s1_n_dom",     n_dom, 60);
        chk("s1_fld1",      int'(rec_fld[1]), 5'b11000);
        chk("s1_fld61",     int'(rec_fld[61]), 5'b11011);
        chk("s1_fld70",     int'(rec_fld[70]), 5'b11011);
        chk("s1_fld71",     int'(rec_fld[71]), 5'b11001);
        chk("s1_fld140",    int'(rec_fld[140]), 5'b11001);
        chk("s1_act140",    int'(rec_act[140]), 1);
        chk("s1_act0",      int'(rec_act[0]), 0);
`ifdef CAN_INTERMISSION_EN
        chk("s1_fld141",    int'(rec_fld[141]), 5'b11010);
        chk("s1_fld170",    int'(rec_fld[170]), 5'b11010);
        chk("s1_fld171",    int'(rec_fld[171]), 0);
        chk("s1_done_at",   first_done, 171);
        chk("s1_act171",    int'(rec_act[171]), 0);
`else
        chk("s1_fld141",    int'(rec_fld[141]), 0);
        chk("s1_done_at",   first_done, 141);
        chk("s1_act141",    int'(rec_act[141]), 0);
`endif
        chk("s1_n_done",    n_done, 1);
        chk("s1_n_stuck",   n_stk, 0);

        // 2: passive error flag, same timing, line stays recessive
        run_frame(1'b1, -1, -1, -1, 260);
        analyze(260);
        chk("s2_n_dom",   n_dom, 0);
        chk("s2_fld1",    int'(rec_fld[1]), 5'b11000);
        chk("s2_fld71",   int'(rec_fld[71]), 5'b11001);
        chk("s2_act1",    int'(rec_act[1]), 1);
`ifdef CAN_INTERMISSION_EN
        chk("s2_done_at", first_done, 171);
`else
        chk("s2_done_at", first_done, 141);
`endif

        // 3: superposition, bus dominant for 3 bits after the flag
        run_frame(1'b0, 61, 91, -1, 260);
        analyze(260);
        chk("s3_last_dom", last_dom, 60);
        chk("s3_fld100",   int'(rec_fld[100]), 5'b11011);
        chk("s3_fld101",   int'(rec_fld[101]), 5'b11001);
`ifdef CAN_INTERMISSION_EN
        chk("s3_done_at",  first_done, 201);
`else
        chk("s3_done_at",  first_done, 171);
`endif
        chk("s3_n_done",   n_done, 1);

        // 4: stuck-dominant bus after the flag
        run_frame(1'b0, 61, 10000, -1, 500);
        analyze(500);
        chk("s4_first_stk",  first_stk, 201);
        chk("s4_second_stk", second_stk, 341);
        chk("s4_n_stk",      n_stk, 3);
        chk("s4_n_done",     n_done, 0);
        chk("s4_last_dom",   last_dom, 60);
        chk("s4_fld500",     int'(rec_fld[500]), 5'b11011);
        do_reset();

        // 5: reset mid-flag, then a fresh frame
        run_frame(1'b0, -1, -1, -1, 30);
        chk("s5_pre_tx", int'(o_Tx_Data), 0);
        rst_n = 1'b0;
        #1;
        chk("s5_async_tx",  int'(o_Tx_Data), 1);
        chk("s5_async_act", int'(o_Tx_Active), 0);
        chk("s5_async_fld", int'(o_frame_field), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_frame(1'b0, -1, -1, -1, 260);
        analyze(260);
        chk("s5_first_dom", first_dom, 1);
        chk("s5_n_dom",     n_dom, 60);
        chk("s5_n_done",    n_done, 1);

`ifdef CAN_INTERMISSION_EN
        // 6: error request during intermission is ignored
        run_frame(1'b0, -1, -1, 150, 260);
        analyze(260);
        chk("s6_done_at", first_done, 171);
        chk("s6_n_done",  n_done, 1);
        chk("s6_n_dom",   n_dom, 60);
        chk("s6_fld180",  int'(rec_fld[180]), 0);
`else
        // i_Error arriving on the idle cycle right after completion starts a new frame
        run_frame(1'b0, -1, -1, 140, 260);
        analyze(260);
        chk("s6_done_at", first_done, 141);
        chk("s6_fld142",  int'(rec_fld[142]), 5'b11000);
        chk("s6_n_dom",   n_dom, 120);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
